// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and FSM encoding for the LCD SPI writer
package lcd_pkg;
   localparam int SPI_BITS = 8;
   localparam int WORD_W   = 9;
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_SHIFT = 4'b0010,
      ST_DONE  = 4'b0100,
      ST_GAP   = 4'b1000
   } lcd_state_t;
endpackage

// File: rtl/lcd_spi_clk_div.sv
// rtl/lcd_spi_clk_div.sv - SCLK half-period timer producing rise/fall strobes
module lcd_spi_clk_div #(
   parameter int SCLK_HALF = 2
) (
   input  logic sys_clk_50MHz,
   input  logic sys_rst_n,
   input  logic run,
   output logic rise_stb,
   output logic fall_stb
);
   localparam int CNT_W = $clog2(SCLK_HALF + 1);

   logic [CNT_W-1:0] half_cnt;
   logic             sclk_hi;
   logic             half_end;

   // sclk_hi tracks which half the divider is in, so the first strobe after run is always a rise
   assign half_end = run && (half_cnt == CNT_W'(SCLK_HALF - 1));
   assign rise_stb = half_end && !sclk_hi;
   assign fall_stb = half_end && sclk_hi;

   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         half_cnt <= '0;
         sclk_hi  <= 1'b0;
      end else if (!run) begin
         half_cnt <= '0;
         sclk_hi  <= 1'b0;
      end else if (half_end) begin
         half_cnt <= '0;
         sclk_hi  <= ~sclk_hi;
      end else begin
         half_cnt <= half_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/lcd_spi_write.sv
// rtl/lcd_spi_write.sv - 9-bit {dc, byte} word to 4-wire SPI mode 0 transmitter
module lcd_spi_write
   import lcd_pkg::*;
#(
   parameter int SCLK_HALF  = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic              sys_clk_50MHz,
   input  logic              sys_rst_n,
   input  logic              en_write,
   input  logic [WORD_W-1:0] data_in,
   output logic              wr_done,
   output logic              busy,
   output logic              lcd_sclk,
   output logic              lcd_mosi,
   output logic              lcd_dc,
   output logic              lcd_cs_n
);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   lcd_state_t          state;
   logic [SPI_BITS-1:0] shreg;
   logic [2:0]          bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                rise_stb;
   logic                fall_stb;

   lcd_spi_clk_div #(.SCLK_HALF(SCLK_HALF)) u_clk_div (
      .sys_clk_50MHz (sys_clk_50MHz),
      .sys_rst_n     (sys_rst_n),
      .run           (state == ST_SHIFT),
      .rise_stb      (rise_stb),
      .fall_stb      (fall_stb)
   );

   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         wr_done  <= 1'b0;
         busy     <= 1'b0;
         lcd_sclk <= 1'b0;
         lcd_mosi <= 1'b0;
         lcd_dc   <= DC_CMD;
         lcd_cs_n <= 1'b1;
      end else begin
         wr_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (en_write && gap_cnt == '0) begin
                  shreg    <= data_in[SPI_BITS-1:0];
                  bit_cnt  <= 3'(SPI_BITS - 1);
                  lcd_cs_n <= 1'b0;
                  lcd_dc   <= data_in[WORD_W-1];
                  lcd_mosi <= data_in[SPI_BITS-1];
                  busy     <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (rise_stb) begin
                  lcd_sclk <= 1'b1;
               end else if (fall_stb) begin
                  lcd_sclk <= 1'b0;
                  if (bit_cnt == '0) begin
                     lcd_cs_n <= 1'b1;
                     wr_done  <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     bit_cnt  <= bit_cnt - 1'b1;
                     shreg    <= {shreg[SPI_BITS-2:0], 1'b0};
                     lcd_mosi <= shreg[SPI_BITS-2];
                  end
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               // The IDLE cycle itself is the last gap cycle, so GAP holds for GAP_CYCLES-1
               gap_cnt <= GAP_W'(GAP_CYCLES - 2);
               state   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt == '0) state <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_spi_write.sv
// tb/tb_lcd_spi_write.sv - scoreboard bench with panel-side SPI monitor for lcd_spi_write
module tb_lcd_spi_write;
   import lcd_pkg::*;

   logic              sys_clk_50MHz = 1'b0;
   logic              sys_rst_n     = 1'b0;
   logic              en_write      = 1'b0;
   logic [WORD_W-1:0] data_in       = '0;
   logic              wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n;

   always #10 sys_clk_50MHz = ~sys_clk_50MHz;

   lcd_spi_write #(.SCLK_HALF(2), .GAP_CYCLES(2)) dut (
      .sys_clk_50MHz (sys_clk_50MHz),
      .sys_rst_n     (sys_rst_n),
      .en_write      (en_write),
      .data_in       (data_in),
      .wr_done       (wr_done),
      .busy          (busy),
      .lcd_sclk      (lcd_sclk),
      .lcd_mosi      (lcd_mosi),
      .lcd_dc        (lcd_dc),
      .lcd_cs_n      (lcd_cs_n)
   );

   typedef struct {
      logic [WORD_W-1:0] word;
      bit                chk_gap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int   cyc = 0, latch_cyc = 0, last_latch = -1, spacing = 0, cs_low = 0;
   int   nbits = 0, done_cnt = 0, total_rises = 0;
   logic [7:0] mon_sh = '0;
   logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Panel model: samples MOSI on SCLK rising edges and scores each byte at wr_done
   always @(negedge sys_clk_50MHz) begin
      cyc++;
      if (!sys_rst_n) begin
         nbits     = 0;
         mon_sh    = '0;
         prev_sclk = 1'b0;
         prev_cs   = 1'b1;
         prev_done = 1'b0;
      end else begin
         if (prev_cs && !lcd_cs_n) begin
            spacing    = (last_latch >= 0) ? cyc - last_latch : 0;
            last_latch = cyc;
            latch_cyc  = cyc;
            nbits      = 0;
            cs_low     = 0;
         end
         if (!lcd_cs_n) cs_low++;
         if (!prev_sclk && lcd_sclk) begin
            total_rises++;
            if (!lcd_cs_n) begin
               mon_sh = {mon_sh[6:0], lcd_mosi};
               nbits++;
            end
         end
         if (wr_done) begin
            exp_t e;
            done_cnt++;
            check("wr_done_single_cycle", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
               check("unexpected_wr_done", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("byte", mon_sh, e.word[7:0]);
               check("dc", lcd_dc, e.word[8]);
               check("bit_count", nbits, 8);
               check("cs_low_cycles", cs_low, 32);
               check("latch_to_done", cyc - latch_cyc, 32);
               check("cs_high_at_done", lcd_cs_n, 1'b1);
               if (e.chk_gap) check("latch_spacing", spacing, 35);
            end
         end
         prev_sclk = lcd_sclk;
         prev_cs   = lcd_cs_n;
         prev_done = wr_done;
      end
   end

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge sys_clk_50MHz);
         n++;
      end
      check("wait_done_in_budget", done_cnt, target);
   endtask

   task automatic wait_bits(input int target);
      int n = 0;
      do begin
         @(negedge sys_clk_50MHz);
         #1;
         n++;
      end while (nbits < target && n < 200);
      check("wait_bits_in_budget", (nbits >= target), 1'b1);
   endtask

   task automatic send_pulse(input logic [WORD_W-1:0] word);
      int base = done_cnt;
      @(posedge sys_clk_50MHz); #1;
      exp_q.push_back('{word, 1'b0});
      data_in  = word;
      en_write = 1'b1;
      @(posedge sys_clk_50MHz); #1;
      en_write = 1'b0;
      data_in  = 9'h0FF;
      wait_done(base + 1, 100);
      repeat (5) @(posedge sys_clk_50MHz);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WORD_W-1:0] seq_words [3];
      int base, rises0;

      repeat (3) @(posedge sys_clk_50MHz);
      #1;
      check("rst_sclk", lcd_sclk, 1'b0);
      check("rst_mosi", lcd_mosi, 1'b0);
      check("rst_dc", lcd_dc, 1'b0);
      check("rst_cs_n", lcd_cs_n, 1'b1);
      check("rst_wr_done", wr_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      sys_rst_n = 1'b1;
      repeat (100) @(posedge sys_clk_50MHz);
      #1;
      check("idle_sclk_rises", total_rises, 0);
      check("idle_wr_done", done_cnt, 0);

      send_pulse({DC_CMD, 8'h11});
      rises0 = total_rises;
      send_pulse({DC_DATA, 8'hA5});
      check("sclk_rises_1a5", total_rises - rises0, 8);

      // Upstream sequencer: en_write held, data_in stepped two cycles after wr_done
      seq_words[0] = {DC_CMD, 8'h2A};
      seq_words[1] = {DC_DATA, 8'h00};
      seq_words[2] = {DC_DATA, 8'hEF};
      base = done_cnt;
      @(posedge sys_clk_50MHz); #1;
      exp_q.push_back('{seq_words[0], 1'b0});
      exp_q.push_back('{seq_words[1], 1'b1});
      exp_q.push_back('{seq_words[2], 1'b1});
      data_in  = seq_words[0];
      en_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_done(base + i + 1, 200);
         @(posedge sys_clk_50MHz); #1;
         if (i < 2) data_in = seq_words[i + 1];
         else       en_write = 1'b0;
      end
      repeat (10) @(posedge sys_clk_50MHz);

      // en_write dropped mid-byte
      base = done_cnt;
      @(posedge sys_clk_50MHz); #1;
      exp_q.push_back('{9'h13F, 1'b0});
      data_in  = 9'h13F;
      en_write = 1'b1;
      @(posedge sys_clk_50MHz);
      wait_bits(2);
      @(posedge sys_clk_50MHz); #1;
      en_write = 1'b0;
      data_in  = 9'h000;
      wait_done(base + 1, 100);
      rises0 = total_rises;
      repeat (200) @(posedge sys_clk_50MHz);
      #1;
      check("drop_idle_rises", total_rises - rises0, 0);
      check("drop_idle_done", done_cnt, base + 1);
      check("drop_idle_cs_n", lcd_cs_n, 1'b1);
      check("drop_idle_busy", busy, 1'b0);

      // Reset during bit 4: aborted byte must not complete
      base = done_cnt;
      @(posedge sys_clk_50MHz); #1;
      data_in  = 9'h1C3;
      en_write = 1'b1;
      @(posedge sys_clk_50MHz);
      wait_bits(3);
      repeat (3) @(posedge sys_clk_50MHz);
      #1;
      sys_rst_n = 1'b0;
      en_write  = 1'b0;
      #1;
      check("abort_cs_n", lcd_cs_n, 1'b1);
      check("abort_sclk", lcd_sclk, 1'b0);
      check("abort_wr_done", wr_done, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_dc", lcd_dc, 1'b0);
      repeat (3) @(posedge sys_clk_50MHz);
      #1;
      sys_rst_n = 1'b1;
      send_pulse({DC_CMD, 8'h29});
      check("after_reset_done_count", done_cnt, base + 1);

      repeat (5) @(posedge sys_clk_50MHz);
      check("total_wr_done", done_cnt, 7);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
